// File: rtl/motor_ramp_scheduler.sv
// Time-shared ramp engine for a bank of H-bridge motor channels: slews applied duty
// toward host targets once per tick, forces reversals through zero, handles estop/watchdog.

module motor_ramp_lane #(
    parameter int HW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          visit,
    input  logic [15:0]   visit_mag,
    input  logic          visit_dir,
    input  logic [HW-1:0] visit_hold,
    input  logic          wr,
    input  logic [16:0]   wr_data,
    input  logic          clr_tgt,
    input  logic          estop,
    input  logic          enable,
    output logic [15:0]   cur_mag,
    output logic          cur_dir,
    output logic [15:0]   tgt_mag,
    output logic          tgt_dir,
    output logic [HW-1:0] hold,
    output logic          on,
    output logic          at_target
);
    logic [15:0]   cur_mag_nxt, tgt_mag_nxt;
    logic          cur_dir_nxt, tgt_dir_nxt;
    logic [HW-1:0] hold_nxt;

    always_comb begin
        cur_mag_nxt = cur_mag;
        cur_dir_nxt = cur_dir;
        tgt_mag_nxt = tgt_mag;
        tgt_dir_nxt = tgt_dir;
        hold_nxt    = hold;
        if (clr_tgt) tgt_mag_nxt = '0;
        // A same-cycle write overrides watchdog zeroing for this channel
        if (wr) begin
            tgt_mag_nxt = wr_data[15:0];
            tgt_dir_nxt = wr_data[16];
        end
        if (visit) begin
            cur_mag_nxt = visit_mag;
            cur_dir_nxt = visit_dir;
            hold_nxt    = visit_hold;
        end
        if (estop) begin
            cur_mag_nxt = '0;
            tgt_mag_nxt = '0;
            hold_nxt    = '0;
        end
    end

    // on/at_target are computed from next state so they line up with duty/dir
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_mag   <= '0;
            cur_dir   <= 1'b0;
            tgt_mag   <= '0;
            tgt_dir   <= 1'b0;
            hold      <= '0;
            on        <= 1'b0;
            at_target <= 1'b1;
        end else begin
            cur_mag   <= cur_mag_nxt;
            cur_dir   <= cur_dir_nxt;
            tgt_mag   <= tgt_mag_nxt;
            tgt_dir   <= tgt_dir_nxt;
            hold      <= hold_nxt;
            on        <= enable & ~estop & (cur_mag_nxt != '0) & (hold_nxt == '0);
            at_target <= (cur_mag_nxt == tgt_mag_nxt) & (cur_dir_nxt == tgt_dir_nxt) &
                         (hold_nxt == '0);
        end
    end
endmodule

module motor_ramp_scheduler #(
    parameter int          NUM_MOTORS   = 8,
    parameter int          AW           = $clog2(NUM_MOTORS),
    parameter int          PRESCALE     = 50000,
    parameter logic [15:0] STEP         = 16'd64,
    parameter int          REVERSE_HOLD = 8,
    parameter int          WDT_TICKS    = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [16:0]             wr_data,
    input  logic                    enable,
    input  logic                    estop,
    output logic [NUM_MOTORS-1:0]   dir,
    output logic [NUM_MOTORS-1:0]   on,
    output logic [16*NUM_MOTORS-1:0] duty_cycle,
    output logic [NUM_MOTORS-1:0]   at_target,
    output logic                    wdt_expired
);
    localparam int HW = $clog2(REVERSE_HOLD + 1);
    localparam int PW = $clog2(PRESCALE);
    localparam int WW = $clog2(WDT_TICKS + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t  state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [PW-1:0] pre_cnt;
    logic [WW-1:0] wdt_cnt;
    logic          tick, wr_ok, fire;

    logic [NUM_MOTORS-1:0][15:0]   cur_mag, tgt_mag;
    logic [NUM_MOTORS-1:0]         cur_dir, tgt_dir, visit, wr_sel;
    logic [NUM_MOTORS-1:0][HW-1:0] hold;

    logic [15:0]   v_mag, v_tgt, n_mag;
    logic          v_dir, v_tdir, n_dir;
    logic [HW-1:0] v_hold, n_hold;
    logic [16:0]   up, dn;

    assign tick  = (pre_cnt == PW'(PRESCALE - 1));
    assign wr_ok = wr_en & ~estop & (int'(wr_addr) < NUM_MOTORS);
    assign fire  = tick & ~wdt_expired & (wdt_cnt == WW'(WDT_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pre_cnt <= '0;
        else          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    // Watchdog counts ticks since the last accepted write and sticks once fired
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt     <= '0;
            wdt_expired <= 1'b0;
        end else if (wr_ok) begin
            wdt_cnt     <= '0;
            wdt_expired <= 1'b0;
        end else if (fire) begin
            wdt_expired <= 1'b1;
        end else if (tick && !wdt_expired) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: if (tick && !estop) begin
                state_nxt = SCAN;
                idx_nxt   = '0;
            end
            SCAN: begin
                if (estop || idx == AW'(NUM_MOTORS - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Shared update engine for the channel selected by idx; 17-bit math avoids wrap
    always_comb begin
        v_mag  = cur_mag[idx];
        v_tgt  = tgt_mag[idx];
        v_dir  = cur_dir[idx];
        v_tdir = tgt_dir[idx];
        v_hold = hold[idx];
        n_mag  = v_mag;
        n_dir  = v_dir;
        n_hold = v_hold;
        up     = {1'b0, v_mag} + {1'b0, STEP};
        dn     = {1'b0, v_mag} - {1'b0, STEP};
        if (v_hold != '0) begin
            n_hold = v_hold - HW'(1);
        end else if (v_dir != v_tdir) begin
            if (v_mag != '0) begin
                n_mag = dn[16] ? '0 : dn[15:0];
            end else begin
                n_dir  = v_tdir;
                n_hold = HW'(REVERSE_HOLD);
            end
        end else if (v_mag < v_tgt) begin
            n_mag = (up > {1'b0, v_tgt}) ? v_tgt : up[15:0];
        end else if (v_mag > v_tgt) begin
            n_mag = (dn[16] || dn[15:0] < v_tgt) ? v_tgt : dn[15:0];
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_lane
        assign visit[i]  = (state == SCAN) && (idx == AW'(i));
        assign wr_sel[i] = wr_ok && (wr_addr == AW'(i));

        motor_ramp_lane #(.HW(HW)) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .visit      (visit[i]),
            .visit_mag  (n_mag),
            .visit_dir  (n_dir),
            .visit_hold (n_hold),
            .wr         (wr_sel[i]),
            .wr_data    (wr_data),
            .clr_tgt    (fire),
            .estop      (estop),
            .enable     (enable),
            .cur_mag    (cur_mag[i]),
            .cur_dir    (cur_dir[i]),
            .tgt_mag    (tgt_mag[i]),
            .tgt_dir    (tgt_dir[i]),
            .hold       (hold[i]),
            .on         (on[i]),
            .at_target  (at_target[i])
        );
    end

    assign dir        = cur_dir;
    assign duty_cycle = cur_mag;
endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// Directed bench for motor_ramp_scheduler: ramp, reversal, scan latency, estop, enable,
// watchdog and mid-scan reset, with hand-computed expectations.

module tb_motor_ramp_scheduler;
    localparam int P = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, wr_en6;
    logic [2:0]  wr_addr;
    logic [16:0] wr_data;
    logic        enable, estop;

    logic [7:0]   dir, on, at_target;
    logic [127:0] duty;
    logic         wdt;
    logic [5:0]   dir6, on6, at6;
    logic [95:0]  duty6;
    logic         wdt6;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;

    always #5 clk = ~clk;

    motor_ramp_scheduler #(
        .NUM_MOTORS(8), .PRESCALE(P), .STEP(16'd64), .REVERSE_HOLD(8), .WDT_TICKS(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .enable(enable), .estop(estop), .dir(dir), .on(on), .duty_cycle(duty),
        .at_target(at_target), .wdt_expired(wdt)
    );

    motor_ramp_scheduler #(
        .NUM_MOTORS(6), .PRESCALE(P), .STEP(16'd64), .REVERSE_HOLD(8), .WDT_TICKS(4)
    ) dut6 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en6), .wr_addr(wr_addr), .wr_data(wr_data),
        .enable(enable), .estop(estop), .dir(dir6), .on(on6), .duty_cycle(duty6),
        .at_target(at6), .wdt_expired(wdt6)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [15:0] d8(input int ch);
        return duty[ch*16 +: 16];
    endfunction

    function automatic logic [15:0] d6(input int ch);
        return duty6[ch*16 +: 16];
    endfunction

    // Step to the next cycle whose edge count modulo P equals ph (scan window is 0..8)
    task automatic sync(input int ph);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % P != ph);
    endtask

    task automatic tick_n(input int n);
        repeat (n) sync(12);
    endtask

    task automatic wr(input logic [2:0] a, input logic [16:0] d, input bit six);
        wr_addr = a;
        wr_data = d;
        if (six) wr_en6 = 1'b1;
        else     wr_en  = 1'b1;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        wr_en6 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_en6 = 1'b0; wr_addr = '0; wr_data = '0;
        enable = 1'b0; estop = 1'b0;
        #23;
        @(negedge clk) reset_n = 1'b1;
        sync(12);

        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_on", 32'(on), 32'h0);
        chk("rst_duty_lo", duty[31:0], 32'h0);
        chk("rst_at_target", 32'(at_target), 32'hFF);
        chk("rst_wdt", 32'(wdt), 32'h0);

        // Forward ramp 0 -> 200
        enable = 1'b1;
        wr(3'd0, {1'b0, 16'd200}, 1'b0);
        chk("ramp_at_target_drop", 32'(at_target[0]), 32'h0);
        tick_n(1);
        chk("ramp_d64", 32'(d8(0)), 64);
        chk("ramp_on", 32'(on[0]), 1);
        tick_n(1); chk("ramp_d128", 32'(d8(0)), 128);
        tick_n(1); chk("ramp_d192", 32'(d8(0)), 192);
        chk("ramp_not_at", 32'(at_target[0]), 0);
        tick_n(1); chk("ramp_d200", 32'(d8(0)), 200);
        chk("ramp_at", 32'(at_target[0]), 1);

        // Reversal through zero with dwell
        wr(3'd0, {1'b0, 16'd128}, 1'b0);
        tick_n(1); chk("dec_d136", 32'(d8(0)), 136);
        tick_n(1); chk("dec_d128", 32'(d8(0)), 128);
        wr(3'd0, {1'b1, 16'd100}, 1'b0);
        tick_n(1); chk("rev_d64", 32'(d8(0)), 64);
        chk("rev_dir_kept", 32'(dir[0]), 0);
        tick_n(1); chk("rev_d0", 32'(d8(0)), 0);
        chk("rev_on0", 32'(on[0]), 0);
        chk("rev_dir_not_yet", 32'(dir[0]), 0);
        tick_n(1); chk("rev_flip", 32'(dir[0]), 1);
        chk("rev_flip_on", 32'(on[0]), 0);
        tick_n(7); chk("rev_hold_d", 32'(d8(0)), 0);
        chk("rev_hold_on", 32'(on[0]), 0);
        tick_n(1); chk("rev_hold_end_d", 32'(d8(0)), 0);
        tick_n(1); chk("rev_d64_up", 32'(d8(0)), 64);
        chk("rev_on1", 32'(on[0]), 1);
        tick_n(1); chk("rev_d100", 32'(d8(0)), 100);
        chk("rev_at", 32'(at_target[0]), 1);

        // Two channels in one scan: ch5 lands two cycles after ch3
        wr(3'd3, {1'b0, 16'd128}, 1'b0);
        wr(3'd5, {1'b0, 16'd128}, 1'b0);
        sync(3); chk("lat_ch3_early", 32'(d8(3)), 0);
        sync(4); chk("lat_ch3", 32'(d8(3)), 64);
        chk("lat_ch5_wait", 32'(d8(5)), 0);
        sync(5); chk("lat_ch5_still", 32'(d8(5)), 0);
        sync(6); chk("lat_ch5", 32'(d8(5)), 64);
        sync(12);

        // Out-of-range address on the six-channel instance is ignored
        wr(3'd7, {1'b0, 16'd500}, 1'b1);
        tick_n(1);
        chk("oob_at6", 32'(at6), 32'h3F);
        chk("oob_duty6", duty6[31:0], 0);

        // Emergency stop
        wr(3'd2, {1'b0, 16'd300}, 1'b0);
        tick_n(5); chk("es_pre300", 32'(d8(2)), 300);
        chk("es_pre_on", 32'(on[2]), 1);
        estop = 1'b1;
        wr_addr = 3'd2; wr_data = {1'b0, 16'd500}; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; estop = 1'b0;
        chk("es_on", 32'(on), 0);
        chk("es_duty2", 32'(d8(2)), 0);
        chk("es_duty0", 32'(d8(0)), 0);
        chk("es_dir_kept", 32'(dir[0]), 1);
        tick_n(2);
        chk("es_after_d2", 32'(d8(2)), 0);
        chk("es_after_at2", 32'(at_target[2]), 1);

        // Enable gates on only
        enable = 1'b0;
        wr(3'd4, {1'b0, 16'd256}, 1'b0);
        tick_n(1); chk("en_d64", 32'(d8(4)), 64);
        chk("en_off", 32'(on[4]), 0);
        tick_n(1); chk("en_d128", 32'(d8(4)), 128);
        chk("en_off2", 32'(on[4]), 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("en_on", 32'(on[4]), 1);
        chk("en_on_d", 32'(d8(4)), 128);
        tick_n(1); chk("en_d192", 32'(d8(4)), 192);

        // Watchdog on the six-channel instance
        chk("wdt_idle_fired", 32'(wdt6), 1);
        wr(3'd1, {1'b0, 16'd256}, 1'b1);
        chk("wdt_clr", 32'(wdt6), 0);
        tick_n(2); chk("wdt_d128", 32'(d6(1)), 128);
        wr(3'd1, {1'b0, 16'd256}, 1'b1);
        tick_n(2); chk("wdt_d256", 32'(d6(1)), 256);
        tick_n(1); chk("wdt_not_yet", 32'(wdt6), 0);
        tick_n(1); chk("wdt_fire", 32'(wdt6), 1);
        chk("wdt_d192", 32'(d6(1)), 192);
        tick_n(1); chk("wdt_d128b", 32'(d6(1)), 128);
        tick_n(2); chk("wdt_d0", 32'(d6(1)), 0);
        chk("wdt_sticky", 32'(wdt6), 1);
        wr(3'd1, {1'b0, 16'd0}, 1'b1);
        chk("wdt_clr2", 32'(wdt6), 0);

        // Reset in the middle of a scan
        wr(3'd4, {1'b0, 16'd1000}, 1'b0);
        sync(3);
        reset_n = 1'b0;
        #1;
        chk("mrst_duty_lo", duty[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        chk("mrst_duty_hi", duty[127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        chk("mrst_dir", 32'(dir), 0);
        chk("mrst_on", 32'(on), 0);
        chk("mrst_at", 32'(at_target), 32'hFF);
        #20;
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
